dmem_arbiter: RTL and testbench

- Shares the single-port data memory between the CPU load/store path and a debug/DMA host port.
- Performs per-cycle arbitration with CPU priority, a starvation guard for the debug port, and bounded debug bursts.
- Tags each read so the 1-cycle-latency memory read data is returned to the correct requester.
- Sits between the CPU datapath (ALU address, RF store data, MemRead/MemWrite) and the data memory. The CPU freezes its PC while `cpu_stall` is high.

---
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port memory between the CPU load/store path and a
// debug/DMA port, with CPU priority, a debug starvation guard and bounded debug bursts.
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned BURST    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] MaxWait  = 4'(MAX_WAIT);
    localparam logic [3:0] BurstLen = 4'(BURST);

    typedef enum logic [0:0] {StArb, StBurst} state_e;

    state_e            state_q;
    logic [3:0]        wait_q;
    logic [3:0]        burst_q;
    logic              tag_valid_q;
    logic              tag_dbg_q;
    logic              cpu_rvalid_q;
    logic              dbg_rvalid_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;

    logic cpu_grant;
    logic dbg_grant;
    logic burst_continue;
    logic rd_grant;

    assign burst_continue = (state_q == StBurst) && dbg_req && (burst_q < BurstLen);

    // On burst exit the cycle is re-arbitrated, but the CPU wins any conflict so bursts never chain.
    always_comb begin
        cpu_grant = 1'b0;
        dbg_grant = 1'b0;
        if (reset) begin
            if (burst_continue) begin
                dbg_grant = 1'b1;
            end else if (cpu_req && dbg_req) begin
                if ((state_q == StArb) && (wait_q >= MaxWait)) begin
                    dbg_grant = 1'b1;
                end else begin
                    cpu_grant = 1'b1;
                end
            end else if (cpu_req) begin
                cpu_grant = 1'b1;
            end else if (dbg_req) begin
                dbg_grant = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (reset) begin
            mem_addr  = dbg_grant ? dbg_addr  : cpu_addr;
            mem_wdata = dbg_grant ? dbg_wdata : cpu_wdata;
        end
        mem_wen   = (cpu_grant && cpu_we) || (dbg_grant && dbg_we);
        mem_ren   = (cpu_grant && !cpu_we) || (dbg_grant && !dbg_we);
        cpu_stall = cpu_req && !cpu_grant;
        dbg_gnt   = dbg_grant;
    end

    assign rd_grant = mem_ren;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StArb;
            wait_q  <= '0;
            burst_q <= '0;
        end else begin
            if (burst_continue) begin
                burst_q <= burst_q + 4'd1;
            end else if (dbg_grant) begin
                state_q <= StBurst;
                burst_q <= 4'd1;
            end else begin
                state_q <= StArb;
                burst_q <= '0;
            end

            if (!dbg_req || dbg_grant) begin
                wait_q <= '0;
            end else if (wait_q < MaxWait) begin
                wait_q <= wait_q + 4'd1;
            end
        end
    end

    // Read tag follows the grant by one cycle; data and valid follow the tag by one more.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_valid_q  <= 1'b0;
            tag_dbg_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            tag_valid_q  <= rd_grant;
            tag_dbg_q    <= dbg_grant;
            cpu_rvalid_q <= tag_valid_q && !tag_dbg_q;
            dbg_rvalid_q <= tag_valid_q && tag_dbg_q;
            if (tag_valid_q && !tag_dbg_q) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (tag_valid_q && tag_dbg_q) begin
                dbg_rdata_q <= mem_rdata;
            end
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory (1-cycle read latency).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        dbg_req, dbg_we;
    logic [9:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt;
    logic [31:0] dbg_rdata;
    logic        dbg_rvalid;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wen, mem_ren;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W  (10),
        .DATA_W  (32),
        .MAX_WAIT(4),
        .BURST   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_stall (cpu_stall),
        .cpu_rdata (cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_gnt   (dbg_gnt),
        .dbg_rdata (dbg_rdata),
        .dbg_rvalid(dbg_rvalid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[10'h010] = 32'h12345678;
        mem[10'h020] = 32'hAAAA0000;
        mem[10'h021] = 32'h0000BBBB;
        mem_rdata = 32'h0;
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3FF; cpu_wdata = 32'hFFFF_FFFF;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'h155; dbg_wdata = 32'h5555_5555;

        // In reset: memory side quiet, stall mirrors request
        to_neg();
        chk("rst_stall", {31'b0, cpu_stall}, 32'd1);
        chk("rst_gnt", {31'b0, dbg_gnt}, 32'd0);
        chk("rst_en", {30'b0, mem_wen, mem_ren}, 32'd0);
        chk("rst_addr", {22'b0, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        next_cyc();
        cpu_req = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
        next_cyc();
        reset = 1'b1;

        // Idle after reset
        to_neg();
        chk("idle_stall", {31'b0, cpu_stall}, 32'd0);
        chk("idle_gnt", {31'b0, dbg_gnt}, 32'd0);
        chk("idle_en", {30'b0, mem_wen, mem_ren}, 32'd0);
        chk("idle_rv", {30'b0, cpu_rvalid, dbg_rvalid}, 32'd0);
        chk("idle_crd", cpu_rdata, 32'd0);
        chk("idle_drd", dbg_rdata, 32'd0);

        // CPU load from 0x010
        next_cyc();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
        to_neg();
        chk("ld_ren", {31'b0, mem_ren}, 32'd1);
        chk("ld_addr", {22'b0, mem_addr}, 32'h010);
        chk("ld_stall", {31'b0, cpu_stall}, 32'd0);
        next_cyc();
        cpu_req = 1'b0;
        to_neg();
        chk("ld_c1_rv", {31'b0, cpu_rvalid}, 32'd0);
        next_cyc();
        to_neg();
        chk("ld_c2_rv", {31'b0, cpu_rvalid}, 32'd1);
        chk("ld_c2_rd", cpu_rdata, 32'h12345678);
        chk("ld_c2_drv", {31'b0, dbg_rvalid}, 32'd0);
        next_cyc();
        to_neg();
        chk("ld_c3_rv", {31'b0, cpu_rvalid}, 32'd0);

        // Contention: CPU 0-3, debug 4-7 (starvation guard + burst), CPU again from 8
        next_cyc();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h030;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'h040; dbg_wdata = 32'hCAFE0001;
        for (int i = 0; i < 10; i++) begin
            to_neg();
            chk($sformatf("cont_gnt%0d", i), {31'b0, dbg_gnt}, {31'b0, (i >= 4 && i <= 7)});
            chk($sformatf("cont_stall%0d", i), {31'b0, cpu_stall}, {31'b0, (i >= 4 && i <= 7)});
            if (i == 4) begin
                chk("cont_addr4", {22'b0, mem_addr}, 32'h040);
                chk("cont_wen4", {31'b0, mem_wen}, 32'd1);
            end
            next_cyc();
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        to_neg();
        chk("cont_mem", mem[10'h040], 32'hCAFE0001);
        next_cyc();

        // Debug alone, six writes: granted every cycle
        for (int i = 0; i < 6; i++) begin
            dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'h100 + 10'(i); dbg_wdata = 32'(i + 16);
            to_neg();
            chk($sformatf("solo_gnt%0d", i), {31'b0, dbg_gnt}, 32'd1);
            chk($sformatf("solo_addr%0d", i), {22'b0, mem_addr}, 32'h100 + 32'(i));
            next_cyc();
        end
        dbg_req = 1'b0;
        to_neg();
        chk("solo_mem3", mem[10'h103], 32'd19);
        next_cyc();

        // Debug burst with CPU joining at cycle 2: debug 0-3, CPU wins at 4 and 5
        for (int i = 0; i < 6; i++) begin
            dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'h200 + 10'(i); dbg_wdata = 32'(i);
            cpu_req = (i >= 2); cpu_we = 1'b1; cpu_addr = 10'h300; cpu_wdata = 32'h77;
            to_neg();
            chk($sformatf("bc_gnt%0d", i), {31'b0, dbg_gnt}, {31'b0, (i <= 3)});
            chk($sformatf("bc_stall%0d", i), {31'b0, cpu_stall}, {31'b0, (i == 2 || i == 3)});
            next_cyc();
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        next_cyc();

        // Alternating owners: debug read 0x020 then CPU read 0x021
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'h020;
        to_neg();
        chk("alt_dgnt", {31'b0, dbg_gnt}, 32'd1);
        next_cyc();
        dbg_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h021;
        to_neg();
        chk("alt_cren", {31'b0, mem_ren}, 32'd1);
        chk("alt_cstall", {31'b0, cpu_stall}, 32'd0);
        next_cyc();
        cpu_req = 1'b0;
        to_neg();
        chk("alt_drv", {31'b0, dbg_rvalid}, 32'd1);
        chk("alt_drd", dbg_rdata, 32'hAAAA0000);
        chk("alt_crv0", {31'b0, cpu_rvalid}, 32'd0);
        next_cyc();
        to_neg();
        chk("alt_crv", {31'b0, cpu_rvalid}, 32'd1);
        chk("alt_crd", cpu_rdata, 32'h0000BBBB);
        chk("alt_drv1", {31'b0, dbg_rvalid}, 32'd0);
        chk("alt_dhold", dbg_rdata, 32'hAAAA0000);
        next_cyc();

        // Reset one cycle after a debug read grant discards the return
        mem[10'h020] = 32'h0BAD0BAD;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'h020;
        to_neg();
        chk("rr_gnt", {31'b0, dbg_gnt}, 32'd1);
        next_cyc();
        reset = 1'b0; dbg_req = 1'b0;
        to_neg();
        chk("rr_in_rst_rv", {31'b0, dbg_rvalid}, 32'd0);
        next_cyc();
        reset = 1'b1;
        to_neg();
        chk("rr_rv2", {31'b0, dbg_rvalid}, 32'd0);
        chk("rr_rd2", dbg_rdata, 32'd0);
        next_cyc();
        // Both requesting after release: fresh ARB state, wait count from zero
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h000;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'h001;
        for (int i = 0; i < 5; i++) begin
            to_neg();
            if (i == 0) chk("rr_rv3", {31'b0, dbg_rvalid}, 32'd0);
            chk($sformatf("rr_gnt%0d", i), {31'b0, dbg_gnt}, {31'b0, (i == 4)});
            next_cyc();
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        next_cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
